// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
//   Shared defaults for the tick generator slice.
//   CNT_W_DEF       : default counter/divisor width
//   DEFAULT_DIV_DEF : default divisor loaded at reset
//   NUM_CH_MAX      : largest supported channel count
//   sel_w()         : width of a channel-select field (never below 1 bit)
// -----------------------------------------------------------------------------
package tick_gen_pkg;

  localparam int CNT_W_DEF       = 28;
  localparam int DEFAULT_DIV_DEF = 100000;
  localparam int NUM_CH_MAX      = 8;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// -----------------------------------------------------------------------------
// tick_gen_chan
//   One programmable tick channel. Counts events from 0 up to div; the event
//   on which cnt==div is a wrap: cnt returns to 0, tick pulses for one cycle
//   and sq toggles. A load rewrites div, restarts cnt and swallows any wrap
//   that would have happened on the same edge.
//
//   Ports
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     evt      : count event for this cycle
//     load     : divisor load strobe for this channel
//     load_div : new divisor value
//     wrap     : combinational wrap strobe (feeds the next channel in cascade)
//     tick     : registered one-cycle pulse after each wrap
//     sq       : registered square wave, toggles on each wrap
// -----------------------------------------------------------------------------
module tick_gen_chan #(
  parameter int CNT_W       = tick_gen_pkg::CNT_W_DEF,
  parameter int DEFAULT_DIV = tick_gen_pkg::DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             wrap,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;

  // A load on the same edge wins over a wrap, so it also hides the strobe
  // from any downstream channel.
  assign wrap = evt && !load && (cnt == div);

  // cnt never exceeds div while counting, so cnt+1 cannot overflow CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      div  <= DIV_RST;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      tick <= wrap;
      sq   <= sq ^ wrap;
      if (load) begin
        div <= load_div;
        cnt <= '0;
      end else if (evt) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   NUM_CH independent (or cascaded) programmable tick channels with a shared
//   divisor-load port. Every channel resets to DEFAULT_DIV.
//
//   Build option: define TICK_GEN_CASCADE_EN to chain the channels -- channel
//   0 counts clk cycles (gated by en) and channel k>0 counts the same-cycle
//   wrap strobe of channel k-1, so cascaded ticks coincide with the upstream
//   tick. Without it every channel counts enabled clk cycles.
//
//   Ports
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     en       : global count enable (freezes cnt/sq and blocks ticks when 0)
//     load     : one-cycle divisor-load strobe
//     load_ch  : channel addressed by load; out-of-range indices are ignored
//     load_div : new divisor value
//     tick     : per-channel registered one-cycle pulse
//     sq       : per-channel registered square wave
//
//   NUM_CH must lie in 1..NUM_CH_MAX.
// -----------------------------------------------------------------------------
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [sel_w(NUM_CH)-1:0]  load_ch,
  input  logic [CNT_W-1:0]          load_div,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         sq
);

  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] ld;
  logic [NUM_CH-1:0] wrap;

  // The last channel's strobe (all strobes in independent mode) has no consumer.
  logic unused_wrap;
  assign unused_wrap = ^wrap;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Equality against k also rejects load_ch >= NUM_CH.
    assign ld[k] = load && (int'(load_ch) == k);

`ifdef TICK_GEN_CASCADE_EN
    if (k == 0) begin : g_src
      assign evt[k] = en;
    end else begin : g_src
      // Upstream wrap already implies en=1, so the chain freezes with en.
      assign evt[k] = wrap[k-1];
    end
`else
    assign evt[k] = en;
`endif

    tick_gen_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .evt      (evt[k]),
      .load     (ld[k]),
      .load_div (load_div),
      .wrap     (wrap[k]),
      .tick     (tick[k]),
      .sq       (sq[k])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic              load = 1'b0;
  logic [0:0]        load_ch = '0;
  logic [CNT_W-1:0]  load_div = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: per channel, events remaining before the next wrap.
  int                m_div [NUM_CH];
  int                m_rem [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_sq;

  always #5 clk = ~clk;

  tick_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .tick     (tick),
    .sq       (sq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_div[k] = DEFAULT_DIV;
      m_rem[k] = DEFAULT_DIV;
    end
    m_tick = '0;
    m_sq   = '0;
  endfunction

  // One rising edge worth of behaviour, from the inputs present at that edge.
  function automatic void model_step();
    logic up;
    up = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      logic ev, ldk, w;
`ifdef TICK_GEN_CASCADE_EN
      ev = (k == 0) ? en : up;
`else
      ev = en;
`endif
      ldk = load && (int'(load_ch) == k);
      w   = ev && !ldk && (m_rem[k] == 0);
      if (ldk) begin
        m_div[k] = int'(load_div);
        m_rem[k] = int'(load_div);
      end else if (w) begin
        m_rem[k] = m_div[k];
      end else if (ev) begin
        m_rem[k] = m_rem[k] - 1;
      end
      m_tick[k] = w;
      if (w) m_sq[k] = ~m_sq[k];
      up = w;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("sq", 32'(sq), 32'(m_sq));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Asserts reset away from a clock edge, checks the asynchronous clear,
  // then releases so the next rising edge is cycle 1.
  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    #1;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sq", 32'(sq), 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic load_one(input int ch, input int dv);
    load     = 1'b1;
    load_ch  = 1'(ch);
    load_div = CNT_W'(dv);
    cycle();
    load     = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // Free run from reset: ticks on cycles 10, 20, 30.
    en = 1'b1;
    run(9);
    check("c9_tick0", 32'(tick[0]), 32'd0);
    run(1);
    check("c10_tick0", 32'(tick[0]), 32'd1);
    check("c10_sq0", 32'(sq[0]), 32'd1);
`ifndef TICK_GEN_CASCADE_EN
    check("c10_tick", 32'(tick), 32'd3);
`endif
    run(10);
    check("c20_tick0", 32'(tick[0]), 32'd1);
    check("c20_sq0", 32'(sq[0]), 32'd0);
    run(10);
    check("c30_sq0", 32'(sq[0]), 32'd1);

    // Mid-run asynchronous reset, then divisor load on ch1 at cycle 5.
    do_reset();
    en = 1'b1;
    run(4);
    load_one(1, 3);
    run(3);
    run(1);
`ifndef TICK_GEN_CASCADE_EN
    check("ld_c9_tick", 32'(tick), 32'd2);
`endif
    run(1);
    check("ld_c10_tick0", 32'(tick[0]), 32'd1);
    run(3);
`ifndef TICK_GEN_CASCADE_EN
    check("ld_c13_tick1", 32'(tick[1]), 32'd1);
`endif
    run(4);
`ifndef TICK_GEN_CASCADE_EN
    check("ld_c17_tick1", 32'(tick[1]), 32'd1);
`endif

    // en low for edges 4..8: first ch0 tick moves to cycle 15.
    do_reset();
    en = 1'b1;
    run(3);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(6);
    check("gap_c14_tick0", 32'(tick[0]), 32'd0);
    run(1);
    check("gap_c15_tick0", 32'(tick[0]), 32'd1);

    // Load on the wrap edge suppresses that wrap.
    do_reset();
    en = 1'b1;
    run(9);
    load_one(0, 9);
    check("lw_c10_tick0", 32'(tick[0]), 32'd0);
    run(10);
    check("lw_c20_tick0", 32'(tick[0]), 32'd1);

    // div=0: tick[0] stays high from the next-but-one cycle.
    load_one(0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("div0_tick0", 32'(tick[0]), 32'd1);
    end

    // Cascade-style divisors (ch1 ticks every 6 cycles when chained).
    do_reset();
    en = 1'b1;
    load_one(0, 1);
    load_one(1, 2);
    run(24);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(9, 0) != 0);
      load     = ($urandom_range(7, 0) == 0);
      load_ch  = 1'($urandom_range(NUM_CH - 1, 0));
      load_div = CNT_W'($urandom_range(12, 0));
      cycle();
      if ($urandom_range(299, 0) == 0) do_reset();
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent tick channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 28, counter and divisor width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 100000, divisor loaded into every channel at reset.
REQ-004 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1, global count enable.
REQ-007 SHALL have port load, input, 1, one-cycle divisor-load strobe.
REQ-008 SHALL have port load_ch, input, clog2(NUM_CH) (minimum 1), channel index for load.
REQ-009 SHALL have port load_div, input, CNT_W, new divisor value.
REQ-010 SHALL have port tick, output, NUM_CH, per-channel registered one-cycle pulse.
REQ-011 SHALL have port sq, output, NUM_CH, per-channel registered square wave.

Function
REQ-012 Each channel SHALL hold cnt[k] and div[k], both CNT_W bits wide and unsigned.
REQ-013 On a count event with en=1: cnt==div -> cnt<=0 and wrap; otherwise cnt<=cnt+1.
REQ-014 tick[k] SHALL be registered: high for exactly the one cycle after the edge on which channel k wraps, low otherwise.
REQ-015 Period SHALL be div+1 events; with en held high from reset release, the first tick[k] SHALL be high after edge div+1.
REQ-016 div=0 SHALL give a wrap on every event; in clk mode tick stays continuously high while en=1.
REQ-017 sq[k] SHALL toggle on every wrap of channel k, giving period 2*(div+1) events.
REQ-018 en=0 SHALL freeze cnt and sq and force tick low; counting SHALL resume from the frozen cnt.
REQ-019 load=1 with load_ch<NUM_CH SHALL set div[load_ch]<=load_div and cnt[load_ch]<=0, and SHALL suppress that channel's wrap that cycle.
REQ-020 load SHALL take priority over a simultaneous wrap; sq SHALL be unchanged by load.
REQ-021 load SHALL act regardless of en.
REQ-022 load_ch>=NUM_CH SHALL be ignored.
REQ-023 Counter arithmetic SHALL stay within CNT_W; with cnt<=div there is no overflow path.

Reset
REQ-024 rst_n=0 SHALL immediately clear cnt, tick and sq to 0 and set every div to DEFAULT_DIV.
REQ-025 Reset asserted mid-count SHALL discard any partial count.
REQ-026 After deassertion, counting SHALL start on the first rising clk edge with en=1.

Configuration
REQ-027 Macro TICK_GEN_CASCADE_EN SHALL select the channel count-event source.
REQ-028 With TICK_GEN_CASCADE_EN defined: channel 0 counts clk cycles; channel k>0 counts the same-cycle wrap strobe of channel k-1. Cascaded ticks SHALL therefore coincide with the upstream tick, and loading channel k-1 SHALL NOT produce a wrap strobe that cycle.
REQ-029 Without TICK_GEN_CASCADE_EN: every channel counts clk cycles independently.

Structure
REQ-030 Package tick_gen_pkg SHALL hold the CNT_W and DEFAULT_DIV default constants and the NUM_CH maximum.
REQ-031 A sub-module tick_gen_chan SHALL implement one channel: cnt, div, wrap strobe, tick and sq registers, with inputs event, load and load_div.
REQ-032 tick_gen SHALL generate NUM_CH instances of tick_gen_chan and decode load_ch.

Verification (NUM_CH=2, CNT_W=8, DEFAULT_DIV=9)
REQ-033 Reset release, en=1 -> tick[0] and tick[1] high on cycles 10, 20, 30; sq toggles every 10 cycles.
REQ-034 load ch1 with div=3 at cycle 5 -> tick[1] high at cycles 9, 13, 17; tick[0] unaffected.
REQ-035 en low for 5 cycles starting at cycle 4 -> first tick[0] at cycle 15; tick low throughout the gap.
REQ-036 load ch0 with div=0 -> tick[0] continuously high from the next-but-one cycle; sq[0] toggles every cycle.
REQ-037 load at cycle 9 (wrap cycle) with ch0 div=9 -> no tick at cycle 10; next tick[0] at cycle 20.
REQ-038 rst_n pulsed low at cycle 7 -> tick, sq and cnt are 0 asynchronously; div back to 9. With TICK_GEN_CASCADE_EN, ch0 div=1 and ch1 div=2 -> tick[1] every 6 cycles, coincident with tick[0].
